// File: rtl/reg_file_mp_if.sv
// Register file port bundle: read ports, write port and scoreboard controls.
// master = decode/writeback side, slave = the register file itself.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
);
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  we;
  logic [AW-1:0]         wr;
  logic [XLEN-1:0]       wr_data;
  logic                  sb_set;
  logic [AW-1:0]         sb_addr;
  logic                  sb_flush;
  logic                  any_busy;

  modport master (
    output rd_addr, we, wr, wr_data, sb_set, sb_addr, sb_flush,
    input  rd_data, rd_busy, any_busy
  );
  modport slave (
    input  rd_addr, we, wr, wr_data, sb_set, sb_addr, sb_flush,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with per-register write-pending scoreboard.
// Register 0 reads as zero and is never pending.
// Optional macro REGFILE_BYPASS_EN: forward the same-cycle write to readers.
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           pend_q, pend_d;

  // Data array: synchronous write, register 0 never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      regs_q <= '0;
    else if (bus.we && bus.wr != '0)
      regs_q[bus.wr] <= bus.wr_data;
  end

  // Scoreboard next state: flush > set (new writer owns it) > writeback clear.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.sb_flush)
        pend_d[r] = 1'b0;
      else if (bus.sb_set && bus.sb_addr == AW'(r))
        pend_d[r] = 1'b1;
      else if (bus.we && bus.wr == AW'(r))
        pend_d[r] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // Pending bits register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign bus.any_busy = |pend_q;

  // Independent combinational read ports.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
    assign addr = bus.rd_addr[i*AW +: AW];

    // Read mux with optional same-cycle write forwarding.
    always_comb begin
      data = (addr == '0) ? '0 : regs_q[addr];
      busy = pend_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.we && bus.wr != '0 && bus.wr == addr) begin
        data = bus.wr_data;
        busy = bus.sb_set && bus.sb_addr == addr;
      end
`endif
    end

    assign bus.rd_data[i*XLEN +: XLEN] = data;
    assign bus.rd_busy[i]              = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with four read ports.
module tb_reg_file_mp;
  localparam int XLEN = 32, NREGS = 32, NREAD = 4, AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .AW(AW)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input int i);
    return bus.rd_data[i*XLEN +: XLEN];
  endfunction

  task automatic set_rd(input logic [4:0] a0, a1, a2, a3);
    bus.rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wr = '0; bus.wr_data = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.sb_flush = 1'b0;
  endtask

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    set_rd(5, 0, 0, 0);
    #1;
    chk("reset_rd5", rdat(0), 32'h0);
    chk("reset_any_busy", {31'b0, bus.any_busy}, 32'h0);
    chk("reset_rd_busy", {28'b0, bus.rd_busy}, 32'h0);

    // release, write x5 and mark it pending
    @(negedge clk); reset = 1'b0;
    bus.we = 1'b1; bus.wr = 5; bus.wr_data = 32'h0000_0055;
    step();
    @(negedge clk); idle(); bus.sb_set = 1'b1; bus.sb_addr = 5;
    step();
    chk("x5_written", rdat(0), 32'h0000_0055);
    chk("x5_busy", {31'b0, bus.rd_busy[0]}, 32'h1);

    // reset mid-write
    @(negedge clk); idle();
    bus.we = 1'b1; bus.wr = 5; bus.wr_data = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    step();
    @(negedge clk); reset = 1'b0; idle();
    #1;
    chk("rst_mid_write_data", rdat(0), 32'h0);
    chk("rst_mid_write_any_busy", {31'b0, bus.any_busy}, 32'h0);

    // zero register
    @(negedge clk);
    bus.we = 1'b1; bus.wr = 0; bus.wr_data = 32'hFFFF_FFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 0;
    set_rd(0, 0, 0, 0);
    step();
    @(negedge clk); idle();
    #1;
    chk("x0_data", rdat(0), 32'h0);
    chk("x0_rd_busy", {28'b0, bus.rd_busy}, 32'h0);
    chk("x0_any_busy", {31'b0, bus.any_busy}, 32'h0);

    // multi-port read
    @(negedge clk); bus.we = 1'b1; bus.wr = 3; bus.wr_data = 32'h11;
    step();
    @(negedge clk); bus.wr = 7; bus.wr_data = 32'h22;
    step();
    @(negedge clk); idle(); set_rd(3, 7, 3, 0);
    #1;
    chk("mp_p0", rdat(0), 32'h11);
    chk("mp_p1", rdat(1), 32'h22);
    chk("mp_p2", rdat(2), 32'h11);
    chk("mp_p3", rdat(3), 32'h0);

    // scoreboard set / clear / set-beats-clear
    @(negedge clk); bus.sb_set = 1'b1; bus.sb_addr = 9; set_rd(9, 3, 0, 0);
    step();
    @(negedge clk); idle();
    #1;
    chk("sb9_set_busy", {28'b0, bus.rd_busy}, 32'h1);
    chk("sb9_any_busy", {31'b0, bus.any_busy}, 32'h1);
    bus.we = 1'b1; bus.wr = 9; bus.wr_data = 32'h99;
    step();
    @(negedge clk); idle();
    #1;
    chk("sb9_clear_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    chk("sb9_clear_data", rdat(0), 32'h99);
    bus.we = 1'b1; bus.wr = 9; bus.wr_data = 32'h9A;
    bus.sb_set = 1'b1; bus.sb_addr = 9;
    step();
    @(negedge clk); idle();
    #1;
    chk("sb9_set_wins_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
    chk("sb9_set_wins_data", rdat(0), 32'h9A);
    bus.we = 1'b1; bus.wr = 9; bus.wr_data = 32'h9B;
    step();
    @(negedge clk); idle();
    #1;
    chk("sb9_final_clear", {31'b0, bus.any_busy}, 32'h0);

    // flush overrides set
    set_rd(4, 6, 8, 10);
    bus.sb_set = 1'b1; bus.sb_addr = 4; step();
    @(negedge clk); bus.sb_addr = 6; step();
    @(negedge clk); bus.sb_addr = 8; step();
    @(negedge clk);
    chk("pre_flush_busy", {28'b0, bus.rd_busy}, 32'h7);
    bus.sb_addr = 10; bus.sb_flush = 1'b1;
    step();
    @(negedge clk); idle();
    #1;
    chk("flush_any_busy", {31'b0, bus.any_busy}, 32'h0);
    chk("flush_rd_busy", {28'b0, bus.rd_busy}, 32'h0);

    // same-cycle write to a pending register
    bus.we = 1'b1; bus.wr = 12; bus.wr_data = 32'h1234_0000;
    step();
    @(negedge clk); idle(); bus.sb_set = 1'b1; bus.sb_addr = 12;
    step();
    @(negedge clk); idle();
    set_rd(12, 12, 0, 0);
    bus.we = 1'b1; bus.wr = 12; bus.wr_data = 32'hCAFE_0001;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", rdat(0), 32'hCAFE_0001);
    chk("bypass_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
`else
    chk("nobypass_data", rdat(0), 32'h1234_0000);
    chk("nobypass_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
`endif
    step();
    @(negedge clk); idle();
    #1;
    chk("after_write_data", rdat(1), 32'hCAFE_0001);
    chk("after_write_busy", {31'b0, bus.rd_busy[1]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
